// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the keyboard scan-code controller.
//   - PS/2 set-2 scan-code constants (prefixes, modifiers, arrow keys)
//   - character codes pushed for the arrow keys
//   - controller state enum
//   - arrow_char(): maps an arrow scan code to its character code
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [7:0] CH_UP     = 8'h80;
  localparam logic [7:0] CH_DOWN   = 8'h81;
  localparam logic [7:0] CH_LEFT   = 8'h82;
  localparam logic [7:0] CH_RIGHT  = 8'h83;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK,
    ST_LOOKUP,
    ST_WAIT,
    ST_STORE
  } kbd_state_e;

  function automatic logic [7:0] arrow_char(input logic [7:0] sc);
    logic [7:0] ch;
    ch = 8'h00;
    case (sc)
      SC_UP:    ch = CH_UP;
      SC_DOWN:  ch = CH_DOWN;
      SC_LEFT:  ch = CH_LEFT;
      SC_RIGHT: ch = CH_RIGHT;
      default:  ch = 8'h00;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous first-word-fall-through character FIFO.
// Ports:
//   clk, rst       clock, synchronous active-high reset (pointers/count only)
//   push_i         write request; accepted when not full, or when full and
//                  a pop happens in the same cycle
//   push_data_i    byte to write
//   pop_i          read request; ignored while empty
//   head_o         current head byte, 0x00 while empty
//   full_o/empty_o occupancy flags
module kbd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot being written when full.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 scan-code controller. Decodes E0/F0 prefixes, tracks
// Shift (left/right), Ctrl and Caps Lock, looks each make code up in an
// external registered ROM, applies modifiers and queues the character.
// Optional feature macro: KBD_EXTKEYS_EN (arrow keys push 0x80-0x83).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   kbd_event     one-cycle strobe qualifying kbd_byte
//   kbd_byte      received scan-code byte
//   rom_addr      {shift, scancode} ROM address (held between lookups)
//   rom_q         ROM data, one cycle after rom_addr; 0x00 = unmapped
//   data_read     CPU pop strobe
//   data_ready    FIFO not empty
//   data_out      FIFO head, 0x00 when empty
//   caps_lock     Caps Lock state
//   ovf           sticky overflow (dropped event or dropped character)
//   ovf_clr       clears ovf; a coincident new overflow wins
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_event,
  input  logic [7:0] kbd_byte,
  output logic [8:0] rom_addr,
  input  logic [7:0] rom_q,
  input  logic       data_read,
  output logic       data_ready,
  output logic [7:0] data_out,
  output logic       caps_lock,
  output logic       ovf,
  input  logic       ovf_clr
);

  kbd_state_e state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d;
  logic       caps_q, caps_d;
  logic       ovf_q, ovf_d;
  logic [8:0] rom_addr_q, rom_addr_d;
  logic       shift;
  logic       push;
  logic [7:0] push_data;
  logic       ev_drop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] xlat;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  // Caps Lock inverts the letter case chosen by Shift; Ctrl then folds
  // letters onto control codes 0x01-0x1A.
  function automatic logic [7:0] translate(input logic [7:0] c_in,
                                           input logic sh, input logic ct,
                                           input logic cp);
    logic [7:0] c;
    c = c_in;
    if (is_lower(c) && cp && !sh)      c = c - 8'h20;
    else if (is_upper(c) && cp && sh)  c = c + 8'h20;
    if (ct && (is_upper(c) || is_lower(c))) c = c & 8'h1F;
    return c;
  endfunction

  assign shift = lshift_q | rshift_q;
  assign xlat  = translate(rom_q, shift, ctrl_q, caps_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      ctrl_q     <= 1'b0;
      caps_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      ctrl_q     <= ctrl_d;
      caps_q     <= caps_d;
      ovf_q      <= ovf_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    ctrl_d     = ctrl_q;
    caps_d     = caps_q;
    rom_addr_d = rom_addr_q;
    push       = 1'b0;
    push_data  = 8'h00;
    ev_drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (kbd_event) begin
          case (kbd_byte)
            SC_EXT:    state_d  = ST_EXT;
            SC_BREAK:  state_d  = ST_BREAK;
            SC_LSHIFT: lshift_d = 1'b1;
            SC_RSHIFT: rshift_d = 1'b1;
            SC_CTRL:   ctrl_d   = 1'b1;
            SC_CAPS:   caps_d   = ~caps_q;
            default: begin
              // Address is registered here so the ROM sees it next cycle.
              rom_addr_d = {shift, kbd_byte};
              state_d    = ST_LOOKUP;
            end
          endcase
        end
      end

      ST_EXT: begin
        if (kbd_event) begin
          state_d = ST_IDLE;
          case (kbd_byte)
            SC_BREAK: state_d = ST_EXT_BREAK;
            SC_CTRL:  ctrl_d  = 1'b1;
`ifdef KBD_EXTKEYS_EN
            SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT: begin
              push      = 1'b1;
              push_data = arrow_char(kbd_byte);
            end
`endif
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_BREAK: begin
        if (kbd_event) begin
          state_d = ST_IDLE;
          if (kbd_byte == SC_LSHIFT) lshift_d = 1'b0;
          if (kbd_byte == SC_RSHIFT) rshift_d = 1'b0;
          if (kbd_byte == SC_CTRL)   ctrl_d   = 1'b0;
        end
      end

      ST_EXT_BREAK: begin
        if (kbd_event) begin
          state_d = ST_IDLE;
          if (kbd_byte == SC_CTRL) ctrl_d = 1'b0;
        end
      end

      ST_LOOKUP: begin
        ev_drop = kbd_event;
        state_d = ST_WAIT;
      end

      // rom_q is valid in this cycle; the translated character is pushed
      // at its closing edge so it is readable the cycle after.
      ST_WAIT: begin
        ev_drop   = kbd_event;
        push      = (xlat != 8'h00);
        push_data = xlat;
        state_d   = ST_STORE;
      end

      // Recovery cycle that enforces the minimum spacing between codes.
      ST_STORE: begin
        ev_drop = kbd_event;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A push into a full FIFO is lost unless a pop frees a slot this cycle.
    if (ev_drop || (push && fifo_full && !data_read)) ovf_d = 1'b1;
    else if (ovf_clr)                                 ovf_d = 1'b0;
    else                                              ovf_d = ovf_q;
  end

  kbd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (data_read),
    .head_o      (data_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign data_ready = ~fifo_empty;
  assign rom_addr   = rom_addr_q;
  assign caps_lock  = caps_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// tb_kbd_ctrl: directed bench for kbd_ctrl with a registered ROM model.
module tb_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_event = 1'b0;
  logic [7:0] kbd_byte = 8'h00;
  logic [8:0] rom_addr;
  logic [7:0] rom_q = 8'h00;
  logic       data_read = 1'b0;
  logic       data_ready;
  logic [7:0] data_out;
  logic       caps_lock;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  kbd_ctrl #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .kbd_event  (kbd_event),
    .kbd_byte   (kbd_byte),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .data_read  (data_read),
    .data_ready (data_ready),
    .data_out   (data_out),
    .caps_lock  (caps_lock),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  // ROM contents used by the vectors: 'a'/'A' at 0x1C, 'c' at 0x21 in both
  // tables, identity for 0x30..0x4F, everything else unmapped.
  function automatic logic [7:0] rom_fn(input logic [8:0] a);
    logic [7:0] sc;
    sc = a[7:0];
    if (sc == 8'h1C) return a[8] ? 8'h41 : 8'h61;
    if (sc == 8'h21) return 8'h63;
    if (sc >= 8'h30 && sc <= 8'h4F) return sc;
    return 8'h00;
  endfunction

  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  typedef struct {
    logic [7:0] kb;
    logic       chk_addr;
    logic [8:0] addr;
    logic       chk_out;
    logic [7:0] out;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] kb, input logic ca,
                              input logic [8:0] ad, input logic co,
                              input logic [7:0] o);
    vec_t v;
    v.kb = kb; v.chk_addr = ca; v.addr = ad; v.chk_out = co; v.out = o;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte is sampled at the first edge; returns just after that edge.
  task automatic send(input logic [7:0] b);
    kbd_byte  = b;
    kbd_event = 1'b1;
    tick();
    kbd_event = 1'b0;
  endtask

  task automatic pop();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table: each byte followed by three idle cycles.
    add(8'h1C, 1, 9'h01C, 1, 8'h61);
    add(8'h12, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h11C, 1, 8'h41);
    add(8'hF0, 0, 9'h000, 0, 8'h00);
    add(8'h12, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h01C, 1, 8'h61);
    add(8'h58, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h01C, 1, 8'h41);
    add(8'h12, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h11C, 1, 8'h61);
    add(8'h14, 0, 9'h000, 0, 8'h00);
    add(8'h21, 1, 9'h121, 1, 8'h03);
    add(8'hE0, 0, 9'h000, 0, 8'h00);
`ifdef KBD_EXTKEYS_EN
    add(8'h75, 0, 9'h000, 1, 8'h80);
`else
    add(8'h75, 0, 9'h000, 0, 8'h00);
`endif
    add(8'hE0, 0, 9'h000, 0, 8'h00);
    add(8'hF0, 0, 9'h000, 0, 8'h00);
    add(8'h75, 0, 9'h000, 0, 8'h00);
    add(8'h01, 1, 9'h101, 0, 8'h00);
    add(8'hE0, 0, 9'h000, 0, 8'h00);
    add(8'hF0, 0, 9'h000, 0, 8'h00);
    add(8'h14, 0, 9'h000, 0, 8'h00);
    add(8'h21, 1, 9'h121, 1, 8'h63);
    add(8'hF0, 0, 9'h000, 0, 8'h00);
    add(8'h12, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h01C, 1, 8'h41);
    add(8'h59, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h11C, 1, 8'h61);
    add(8'hF0, 0, 9'h000, 0, 8'h00);
    add(8'h59, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h01C, 1, 8'h41);
    add(8'h58, 0, 9'h000, 0, 8'h00);
    add(8'h1C, 1, 9'h01C, 1, 8'h61);

    do_reset();
    chk("reset_ready", data_ready, 0);
    chk("reset_dout", data_out, 8'h00);
    chk("reset_addr", rom_addr, 9'h000);
    chk("reset_caps", caps_lock, 0);
    chk("reset_ovf", ovf, 0);

    // Exact latency of one ordinary key.
    send(8'h1C);
    chk("lat_addr_n1", rom_addr, 9'h01C);
    chk("lat_ready_n1", data_ready, 0);
    tick();
    chk("lat_ready_n2", data_ready, 0);
    tick();
    chk("lat_ready_n3", data_ready, 1);
    chk("lat_dout_n3", data_out, 8'h61);
    tick();
    pop();
    chk("lat_ready_pop", data_ready, 0);
    chk("lat_dout_pop", data_out, 8'h00);

    // Pop while empty is ignored.
    pop();
    chk("empty_pop_ready", data_ready, 0);
    chk("empty_pop_ovf", ovf, 0);

    foreach (vecs[i]) begin
      send(vecs[i].kb);
      if (vecs[i].chk_addr)
        chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].addr);
      ticks(3);
      if (vecs[i].chk_out) begin
        chk($sformatf("vec%0d_ready", i), data_ready, 1);
        chk($sformatf("vec%0d_dout", i), data_out, vecs[i].out);
        pop();
      end
      chk($sformatf("vec%0d_empty", i), data_ready, 0);
    end
    chk("vec_caps_off", caps_lock, 0);
    chk("vec_ovf", ovf, 0);

    // Fill: 17 characters into 16 entries.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'h30 + 8'(i));
      ticks(3);
    end
    chk("fill_ovf", ovf, 1);
    chk("fill_ready", data_ready, 1);
    chk("fill_head", data_out, 8'h30);

    // ovf_clr coinciding with another lost push: set wins.
    send(8'h42);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_vs_set_ovf", ovf, 1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone_ovf", ovf, 0);

    // Push and pop in the same cycle while full: no loss.
    send(8'h41);
    tick();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    tick();
    chk("fullpp_ovf", ovf, 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i < 15) ? 8'h31 + 8'(i) : 8'h41;
      chk($sformatf("drain%0d_ready", i), data_ready, 1);
      chk($sformatf("drain%0d_dout", i), data_out, e);
      pop();
    end
    chk("drain_empty", data_ready, 0);
    chk("drain_dout", data_out, 8'h00);

    // Event during LOOKUP is dropped and flagged.
    send(8'h1C);
    kbd_byte  = 8'h21;
    kbd_event = 1'b1;
    tick();
    kbd_event = 1'b0;
    chk("drop_ovf", ovf, 1);
    tick();
    chk("drop_ready", data_ready, 1);
    chk("drop_dout", data_out, 8'h61);
    pop();
    ticks(4);
    chk("drop_nothing_more", data_ready, 0);

    // Reset asserted while waiting on the ROM.
    send(8'h58);
    ticks(3);
    chk("pre_rst_caps", caps_lock, 1);
    send(8'h1C);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_ready", data_ready, 0);
    chk("wrst_dout", data_out, 8'h00);
    chk("wrst_addr", rom_addr, 9'h000);
    chk("wrst_caps", caps_lock, 0);
    chk("wrst_ovf", ovf, 0);
    ticks(3);
    chk("wrst_no_push", data_ready, 0);
    send(8'h1C);
    chk("post_rst_addr", rom_addr, 9'h01C);
    ticks(3);
    chk("post_rst_dout", data_out, 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
